btree_find: RTL

- Sequential search controller that walks a tree of 128-bit nodes held in external block memory.
- For each node it fetches the block, presents it with the search key to the downstream combinational node-index stage, and consumes that stage's found/data/node result.
- It stops on a hit, on a null child (node 0), or when the depth limit is reached.
- It sits between the search requester and block memory, upstream of the node-index stage.

---
 rtl/btree_find.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/btree_find.sv
// ============================================================================
// btree_find
// ----------------------------------------------------------------------------
// Sequential search controller for a tree of 128-bit nodes held in external
// block memory. Each visited node is fetched, registered, and presented with
// the captured search key to a downstream combinational node-index stage. The
// stage's found/data/node answer decides whether the search ends (hit, null
// child, depth limit) or continues at the returned child address.
//
// Node layout consumed by the index stage (bits [127:56] pass through as-is):
//   keys     [3:0] [7:4] [11:8]
//   data     [15:12] [19:16] [23:20]
//   children [31:24] [39:32] [47:40] [55:48]
//
// Parameters
//   ROOT_ADDRESS  block address of the root node (non-zero)
//   MAX_DEPTH     maximum blocks visited per search (1..15)
//
// Ports
//   clock, reset          rising-edge clock, async active-high reset
//   start, key            search request (accepted only when idle) and key
//   busy, done            not idle / one-cycle completion pulse
//   found, data           hit flag and hit data, held until the next start
//   depth, overflow       blocks visited / search ended at the depth limit
//   mem_req, mem_address  block read request; transfer on mem_req & mem_ack
//   mem_ack, mem_block    read completion and returned block
//   idx_key, idx_block_address, idx_block   operands for the index stage
//   idx_found, idx_data, idx_node           index stage answer
//
// Optional feature (macro BTREE_FIND_STATS_EN)
//   adds saturating 16-bit counters: searches (every done) and hits (done
//   with found set).
//
// Handshake: a block read completes on the rising edge where mem_req and
// mem_ack are both high; mem_req and mem_address stay constant until then.
// ============================================================================
module btree_find #(
    parameter int ROOT_ADDRESS = 1,
    parameter int MAX_DEPTH    = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   key,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [3:0]   data,
    output logic [3:0]   depth,
    output logic         overflow,
    output logic         mem_req,
    output logic [7:0]   mem_address,
    input  logic         mem_ack,
    input  logic [127:0] mem_block,
    output logic [3:0]   idx_key,
    output logic [15:0]  idx_block_address,
    output logic [127:0] idx_block,
    input  logic         idx_found,
    input  logic [3:0]   idx_data,
    input  logic [7:0]   idx_node
`ifdef BTREE_FIND_STATS_EN
    ,
    output logic [15:0]  searches,
    output logic [15:0]  hits
`endif
);

    localparam logic [7:0] ROOT_ADDR = 8'(ROOT_ADDRESS);
    localparam logic [3:0] DEPTH_MAX = 4'(MAX_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_COMPARE = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     key_q, key_d;
    logic [7:0]     addr_q, addr_d;
    logic [3:0]     depth_q, depth_d;
    logic [127:0]   block_q, block_d;
    logic           found_q, found_d;
    logic [3:0]     data_q, data_d;
    logic           ovf_q, ovf_d;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_FETCH;
            S_FETCH:   if (mem_ack) state_d = S_COMPARE;
            S_COMPARE: begin
                // Hit, null child and depth limit all end the search; only
                // a non-null child below the limit continues.
                if (idx_found || (idx_node == 8'd0) || (depth_q == DEPTH_MAX)) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FINISH:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (pure decode of state, so mem_req drops with reset)
    // ------------------------------------------------------------------
    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_FINISH);
        mem_req = (state_q == S_FETCH);
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        key_d   = key_q;
        addr_d  = addr_q;
        depth_d = depth_q;
        block_d = block_q;
        found_d = found_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d   = key;
                    addr_d  = ROOT_ADDR;
                    depth_d = 4'd0;
                    found_d = 1'b0;
                    data_d  = 4'd0;
                    ovf_d   = 1'b0;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    block_d = mem_block;
                    depth_d = depth_q + 4'd1;
                end
            end
            S_COMPARE: begin
                if (idx_found) begin
                    found_d = 1'b1;
                    data_d  = idx_data;
                end else if (idx_node == 8'd0) begin
                    found_d = 1'b0;
                    data_d  = 4'd0;
                end else if (depth_q == DEPTH_MAX) begin
                    ovf_d   = 1'b1;
                    found_d = 1'b0;
                    data_d  = 4'd0;
                end else begin
                    addr_d  = idx_node;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_q   <= 4'd0;
            addr_q  <= 8'd0;
            depth_q <= 4'd0;
            block_q <= 128'd0;
            found_q <= 1'b0;
            data_q  <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            key_q   <= key_d;
            addr_q  <= addr_d;
            depth_q <= depth_d;
            block_q <= block_d;
            found_q <= found_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign found             = found_q;
    assign data              = data_q;
    assign depth             = depth_q;
    assign overflow          = ovf_q;
    assign mem_address       = addr_q;
    assign idx_key           = key_q;
    assign idx_block_address = {8'd0, addr_q};
    assign idx_block         = block_q;

`ifdef BTREE_FIND_STATS_EN
    logic [15:0] searches_q, searches_d;
    logic [15:0] hits_q, hits_d;

    // Counted in the FINISH cycle, where found_q already holds the result.
    always_comb begin
        searches_d = searches_q;
        hits_d     = hits_q;
        if (state_q == S_FINISH) begin
            if (searches_q != 16'hFFFF) searches_d = searches_q + 16'd1;
            if (found_q && (hits_q != 16'hFFFF)) hits_d = hits_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            searches_q <= 16'd0;
            hits_q     <= 16'd0;
        end else begin
            searches_q <= searches_d;
            hits_q     <= hits_d;
        end
    end

    assign searches = searches_q;
    assign hits     = hits_q;
`endif

endmodule
